// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift a byte
// out on device clock falls, then collect the device ACK. Lines are driven only as pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W = $clog2(CNT_MAX + 1);
  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_VAL  = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t           state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [3:0]       bit_cnt, bit_cnt_nx;
  logic             err_rec, err_rec_nx;
  logic             clk_drv_nx, data_drv_nx, done_nx, err_out_nx, accept;
  logic [7:0]       byte_q;

  // Synchronizer stages: p0/p1 resolve metastability, clk_p2 is edge history
  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;
  logic fall, timeout;

  assign fall    = clk_p2 & ~clk_p1;
  assign timeout = (timer == TIMEOUT_VAL);

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    bit_cnt_nx  = bit_cnt;
    err_rec_nx  = err_rec;
    clk_drv_nx  = 1'b0;
    data_drv_nx = 1'b0;
    done_nx     = 1'b0;
    err_out_nx  = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          accept     = 1'b1;
          state_nx   = INHIBIT;
          timer_nx   = '0;
          bit_cnt_nx = '0;
          err_rec_nx = 1'b0;
          clk_drv_nx = 1'b1;
        end
      end
      INHIBIT: begin
        if (timer == INHIBIT_LAST) begin
          state_nx    = RTS;
          timer_nx    = '0;
          data_drv_nx = 1'b1;
        end else begin
          timer_nx   = timer + 1'b1;
          clk_drv_nx = 1'b1;
        end
      end
      default: begin
        // Timeout wins over any fall seen in the same cycle
        if (timeout) begin
          state_nx   = IDLE;
          done_nx    = 1'b1;
          err_out_nx = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
          case (state)
            RTS: begin
              state_nx    = SHIFT;
              data_drv_nx = 1'b1;
            end
            SHIFT: begin
              data_drv_nx = ps2_data_drive_low;
              if (fall) begin
                bit_cnt_nx = bit_cnt + 1'b1;
                if (bit_cnt < 4'd8) begin
                  data_drv_nx = ~byte_q[bit_cnt[2:0]];
                end else if (bit_cnt == 4'd8) begin
                  data_drv_nx = ~odd_parity(byte_q);
                end else begin
                  data_drv_nx = 1'b0;
                  state_nx    = ACK;
                end
              end
            end
            ACK: begin
              if (fall) begin
                err_rec_nx = data_p1;
                state_nx   = WAIT_IDLE;
              end
            end
            WAIT_IDLE: begin
              if (clk_p1 && data_p1) begin
                state_nx   = IDLE;
                done_nx    = 1'b1;
                err_out_nx = err_rec;
              end
            end
            default: state_nx = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      timer              <= '0;
      bit_cnt            <= '0;
      err_rec            <= 1'b0;
      tx_ready           <= 1'b1;
      busy               <= 1'b0;
      tx_done            <= 1'b0;
      tx_err             <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      clk_p0             <= 1'b1;
      clk_p1             <= 1'b1;
      clk_p2             <= 1'b1;
      data_p0            <= 1'b1;
      data_p1            <= 1'b1;
    end else begin
      state              <= state_nx;
      timer              <= timer_nx;
      bit_cnt            <= bit_cnt_nx;
      err_rec            <= err_rec_nx;
      tx_ready           <= (state_nx == IDLE);
      busy               <= (state_nx != IDLE);
      tx_done            <= done_nx;
      tx_err             <= err_out_nx;
      ps2_clk_drive_low  <= clk_drv_nx;
      ps2_data_drive_low <= data_drv_nx;
      clk_p0             <= ps2_clk_in;
      clk_p1             <= clk_p0;
      clk_p2             <= clk_p1;
      data_p0            <= ps2_data_in;
      data_p1            <= data_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) byte_q <= tx_data;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain line model plus a behavioural PS/2 device,
// with expected bits and completion status queued at send time and compared on arrival.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 500;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk_in, ps2_data_in;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready, tx_done, tx_err, busy, ps2_clk_drive_low, ps2_data_drive_low;
  logic dev_clk, dev_data;

  int n_cmp = 0;
  int n_mis = 0;
  int done_count = 0;
  logic exp_bits[$];
  logic exp_err[$];

  always #5 clk = ~clk;

  // Wired-AND of pull-ups, host pull-downs and device pull-downs
  assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
    .tx_err(tx_err), .busy(busy), .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low)
  );

  always @(negedge clk) if (tx_done === 1'b1) done_count <= done_count + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Device-visible frame: 8 data bits LSB first, odd parity, stop
  task automatic push_frame(input logic [7:0] b, input int nbits);
    logic [9:0] f;
    logic par;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0);
    f = {1'b1, par, b};
    for (int i = 0; i < nbits; i++) exp_bits.push_back(f[i]);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept_state", 32'({tx_ready, busy, ps2_clk_drive_low}), 32'b011);
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      if (ps2_clk_drive_low) n++;
      else break;
    end
    check("inhibit_len", 32'(n), 32'(INH));
    check("rts_drive", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'b01);
  endtask

  task automatic device(input logic ack, input int nfalls, input int pulse_fall);
    logic e;
    repeat (4) @(negedge clk);
    for (int f = 1; f <= nfalls; f++) begin
      dev_clk = 1'b0;
      if (f == 11) dev_data = ~ack;
      if (f == pulse_fall) begin
        tx_data = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (19) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      dev_clk = 1'b1;
      if (f <= 10) begin
        e = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
        check($sformatf("frame_bit%0d", f), 32'(ps2_data_in), 32'(e));
      end
      if (f == 11) dev_data = 1'b1;
      if (f < nfalls) repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    logic got;
    logic e;
    n = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      @(negedge clk);
      n++;
      if (tx_done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      e = (exp_err.size() > 0) ? exp_err.pop_front() : 1'bx;
      check("done_err", 32'(tx_err), 32'(e));
      check("done_ready", 32'(tx_ready), 32'd1);
      check("done_lines", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'b00);
      @(negedge clk);
      check("done_width", 32'(tx_done), 32'd0);
    end
  endtask

  initial begin
    int n;
    int busy_cycles;
    int dc;
    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({tx_ready, tx_done, tx_err, busy, ps2_clk_drive_low, ps2_data_drive_low}),
          32'b100000);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outs", 32'({tx_ready, tx_done, busy, ps2_clk_drive_low, ps2_data_drive_low}), 32'b10000);

    // Normal send with ACK
    push_frame(8'hED, 10); exp_err.push_back(1'b0);
    send(8'hED); device(1'b1, 11, 0); wait_done(60, n);

    // Parity corner bytes
    push_frame(8'h00, 10); exp_err.push_back(1'b0);
    send(8'h00); device(1'b1, 11, 0); wait_done(60, n);
    push_frame(8'h01, 10); exp_err.push_back(1'b0);
    send(8'h01); device(1'b1, 11, 0); wait_done(60, n);

    // Device never acknowledges
    push_frame(8'hA5, 10); exp_err.push_back(1'b1);
    send(8'hA5); device(1'b0, 11, 0); wait_done(60, n);

    // Device never clocks: done lands on the edge after the timer reaches TMO
    exp_err.push_back(1'b1);
    send(8'h55); wait_done(700, n);
    check("timeout_at", 32'(n), 32'(TMO + 1));

    // Reset after the fifth fall
    push_frame(8'h3C, 5);
    send(8'h3C); device(1'b1, 5, 0);
    dc = done_count;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst_mid_outs", 32'({tx_ready, tx_done, busy, ps2_clk_drive_low, ps2_data_drive_low}), 32'b10000);
    repeat (30) @(negedge clk);
    check("rst_mid_nodone", 32'(done_count), 32'(dc));
    push_frame(8'hFF, 10); exp_err.push_back(1'b0);
    send(8'hFF); device(1'b1, 11, 0); wait_done(60, n);

    // Request while shifting must be dropped
    push_frame(8'h81, 10); exp_err.push_back(1'b0);
    send(8'h81); device(1'b1, 11, 3); wait_done(60, n);
    busy_cycles = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("no_second_tx", 32'(busy_cycles), 32'd0);

    check("done_total", 32'(done_count), 32'd7);
    check("bits_left", 32'(exp_bits.size()), 32'd0);
    check("err_left", 32'(exp_err.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 keyboard link: sends one command byte (for example 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain clock/data pair the keyboard receive path listens on. It runs on the system clock and synchronizes the raw PS/2 lines internally. It drives the lines only as pull-low enables and reports a per-byte completion with an acknowledge/error status. While it is busy, the keyboard receive path must ignore the link.

## Interface
Parameters:
- INHIBIT_CYCLES, 12000, system clocks the PS/2 clock is held low before request-to-send (120 µs at 100 MHz)
- TIMEOUT_CYCLES, 2000000, maximum system clocks from end of inhibit to transaction completion (20 ms at 100 MHz)

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous)
- ps2_data_in  in  1  raw PS/2 data line level (asynchronous)
- tx_data  in  8  command byte, sampled on acceptance
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high in IDLE; byte accepted on a cycle where tx_valid & tx_ready are both high
- tx_done  out  1  one-cycle pulse at the end of every accepted transaction
- tx_err  out  1  valid only with tx_done: 1 means no ACK or timeout, 0 means the device acknowledged
- busy  out  1  high in every state except IDLE
- ps2_clk_drive_low  out  1  1 pulls the PS/2 clock line low; 0 releases it
- ps2_data_drive_low  out  1  1 pulls the PS/2 data line low; 0 releases it

## Operation
- Input conditioning: each raw line passes through a 2-flop synchronizer plus one history flop. A falling edge (fall) is history=1 and synced=0.
- Frame: start bit (0), 8 data bits LSB first, odd parity bit, then stop (line released).
- Parity bit is ~^tx_data. Examples: 0xED→1, 0x00→1, 0x01→0, 0xFF→1.
- IDLE: both drive outputs 0, tx_ready=1. On acceptance, latch the byte, clear the bit counter and timer, and go to INHIBIT.
- INHIBIT: ps2_clk_drive_low=1 and ps2_data_drive_low=0 for exactly INHIBIT_CYCLES clocks, then go to RTS.
- RTS: for one cycle, ps2_data_drive_low=1 (start bit) and ps2_clk_drive_low=0. The timeout timer starts here. Go to SHIFT.
- SHIFT: the 4-bit counter counts device clock falls. After each fall the data drive updates:
  - falls 1–8: ps2_data_drive_low = ~byte[n-1]
  - fall 9: ps2_data_drive_low = ~parity
  - fall 10: ps2_data_drive_low = 0 (stop bit; line released). Go to ACK.
- ACK: on fall 11, sample synced data. 0 means ACK; 1 records an error. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clock and synced data are both 1. Then pulse tx_done with tx_err set to the recorded status, and return to IDLE.
- Timeout: if the timer reaches TIMEOUT_CYCLES in RTS, SHIFT, ACK or WAIT_IDLE, release both lines in the next cycle, pulse tx_done with tx_err=1, and go to IDLE. Timeout takes priority over a simultaneous fall.
- The clock line is never driven outside INHIBIT. The data line is never driven outside RTS and SHIFT.
- tx_valid while tx_ready=0 is ignored, not queued.

## Timing
- Reset values: tx_ready=1, tx_done=0, tx_err=0, busy=0, both drive outputs 0, state IDLE, counters 0.
- Reset asserted mid-transaction: both lines are released at the first reset edge. No tx_done pulse is issued.
- Acceptance at edge N:
  - edge N+1: tx_ready=0, busy=1, ps2_clk_drive_low=1
  - ps2_clk_drive_low stays 1 for INHIBIT_CYCLES cycles, then RTS drives data low one edge later
- Fall-to-drive latency is 3 clocks from the raw line edge (2 synchronizer clocks plus 1 register). This is well inside the device's roughly 30 µs clock-low half-period.
- tx_done is exactly one cycle wide. tx_ready returns to 1 on the same edge that tx_done asserts.
- Frames are back-to-back capable: a new tx_valid is accepted on the first cycle tx_ready=1.
- All outputs are registered. There are no combinational paths from the PS/2 inputs to the outputs.

## Test plan
- Normal send: INHIBIT_CYCLES=20, byte 0xED, device model clocks at a 40-cycle period and ACKs. Required:
  - clock held low for 20 cycles
  - bits sampled on the device's rising edges read 1,0,1,1,0,1,1,1, then parity 1, then stop 1
  - tx_done=1 with tx_err=0
- Parity check: bytes 0x00 and 0x01 → parity bits sampled as 1 and 0 respectively, both sends complete with tx_err=0.
- No ACK: device model leaves data high on fall 11 → tx_done with tx_err=1, both drives 0 afterwards.
- Timeout: TIMEOUT_CYCLES=500, device model never clocks → at cycle 500 after RTS, tx_done with tx_err=1, lines released, tx_ready=1.
- Reset mid-frame after fall 5 → next cycle both drives 0, tx_ready=1, no tx_done. A following 0xFF send completes with tx_err=0.
- Busy-time ignore: pulse tx_valid during SHIFT with byte 0x12 → exactly one tx_done, and no second transaction starts.
